// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory operation from the ALU, drives a simple
// req/gnt/rvalid memory port and returns an aligned, extended load result.
module load_store_unit #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [5:0]  alu_op,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        done,
   output logic        err,
   output logic [31:0] load_data
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StReq  = 2'd1;
   localparam logic [1:0] StWait = 2'd2;
   localparam logic [1:0] StResp = 2'd3;

   localparam logic [5:0] OpLb  = 6'd1;
   localparam logic [5:0] OpLh  = 6'd2;
   localparam logic [5:0] OpLw  = 6'd3;
   localparam logic [5:0] OpLbu = 6'd5;
   localparam logic [5:0] OpLhu = 6'd6;
   localparam logic [5:0] OpSb  = 6'd18;
   localparam logic [5:0] OpSh  = 6'd19;
   localparam logic [5:0] OpSw  = 6'd20;

   // Counter only needs to hold 0 .. MEM_TIMEOUT-1; the terminal value is detected one early.
   localparam int unsigned CntW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

   logic [1:0]      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [5:0]      op_q, op_d;
   logic [1:0]      ofs_q, ofs_d;
   logic            store_q, store_d;
   logic            misal_q, misal_d;
   logic            err_q, err_d;
   logic            mem_we_q, mem_we_d;
   logic [31:0]     mem_addr_q, mem_addr_d;
   logic [3:0]      mem_be_q, mem_be_d;
   logic [31:0]     mem_wdata_q, mem_wdata_d;
   logic [31:0]     load_data_q, load_data_d;

   logic            dec_valid;
   logic            dec_store;
   logic            dec_misal;
   logic [3:0]      dec_be;
   logic [31:0]     dec_wdata;
   logic [31:0]     lane;
   logic [31:0]     ext_data;
   logic            cnt_expired;

   // Decode the incoming operation: legality, alignment, byte enables and lane replication.
   always_comb begin
      dec_valid = 1'b1;
      dec_store = 1'b0;
      dec_misal = 1'b0;
      dec_be    = 4'b1111;
      dec_wdata = store_data;
      case (alu_op)
         OpLb, OpLbu: ;
         OpLh, OpLhu: dec_misal = addr[0];
         OpLw:        dec_misal = |addr[1:0];
         OpSb: begin
            dec_store = 1'b1;
            dec_be    = 4'b0001 << addr[1:0];
            dec_wdata = {4{store_data[7:0]}};
         end
         OpSh: begin
            dec_store = 1'b1;
            dec_misal = addr[0];
            dec_be    = addr[1] ? 4'b1100 : 4'b0011;
            dec_wdata = {2{store_data[15:0]}};
         end
         OpSw: begin
            dec_store = 1'b1;
            dec_misal = |addr[1:0];
         end
         default: dec_valid = 1'b0;
      endcase
   end

   // Shift the addressed lane down and extend it according to the latched load type.
   always_comb begin
      lane = mem_rdata >> {ofs_q, 3'b000};
      case (op_q)
         OpLb:    ext_data = {{24{lane[7]}}, lane[7:0]};
         OpLbu:   ext_data = {24'h0, lane[7:0]};
         OpLh:    ext_data = {{16{lane[15]}}, lane[15:0]};
         OpLhu:   ext_data = {16'h0, lane[15:0]};
         default: ext_data = mem_rdata;
      endcase
   end

   // Next-state logic for the access FSM, wait counter and latched request fields.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      ofs_d       = ofs_q;
      store_d     = store_q;
      misal_d     = misal_q;
      err_d       = err_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      load_data_d = load_data_q;
      cnt_expired = (cnt_q == CntLast);
      case (state_q)
         StIdle: begin
            if (req_valid && dec_valid) begin
               state_d     = StReq;
               cnt_d       = '0;
               op_d        = alu_op;
               ofs_d       = addr[1:0];
               store_d     = dec_store;
               misal_d     = dec_misal;
               err_d       = 1'b0;
               mem_we_d    = dec_store;
               mem_addr_d  = {addr[31:2], 2'b00};
               mem_be_d    = dec_be;
               mem_wdata_d = dec_wdata;
            end
         end
         StReq: begin
            // Misaligned accesses pass through REQ without ever raising mem_req.
            if (misal_q) begin
               state_d = StResp;
               err_d   = 1'b1;
            end else if (mem_gnt) begin
               state_d = store_q ? StResp : StWait;
               cnt_d   = '0;
            end else if (cnt_expired) begin
               state_d = StResp;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StWait: begin
            if (mem_rvalid) begin
               state_d     = StResp;
               load_data_d = ext_data;
            end else if (cnt_expired) begin
               state_d = StResp;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: begin
            state_d = StIdle;
            err_d   = 1'b0;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         op_q        <= '0;
         ofs_q       <= '0;
         store_q     <= 1'b0;
         misal_q     <= 1'b0;
         err_q       <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         load_data_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         ofs_q       <= ofs_d;
         store_q     <= store_d;
         misal_q     <= misal_d;
         err_q       <= err_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         load_data_q <= load_data_d;
      end
   end

   // Outputs decoded from the current state and latched fields.
   always_comb begin
      req_ready = (state_q == StIdle);
      mem_req   = (state_q == StReq) && !misal_q;
      done      = (state_q == StResp);
      err       = (state_q == StResp) && err_q;
      mem_we    = mem_we_q;
      mem_addr  = mem_addr_q;
      mem_be    = mem_be_q;
      mem_wdata = mem_wdata_q;
      load_data = load_data_q;
   end

endmodule
